// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: generates the load enables and flushes for the PC and the
// IF/ID, ID/EXE, EXE/MEM and MEM/WB registers of a 5-stage ARM pipeline.
// Resolution order each cycle: SRAM wait, branch flush, RAW hazard, normal.
module pipeline_ctrl #(
  parameter int          FORWARD_EN  = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         id_src1,
  input  logic [3:0]         id_src2,
  input  logic               id_two_src,
  input  logic               id_valid,
  input  logic [3:0]         exe_dest,
  input  logic               exe_wb_en,
  input  logic               exe_mem_read,
  input  logic [3:0]         mem_dest,
  input  logic               mem_wb_en,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_load,
  output logic               if_id_load,
  output logic               id_exe_load,
  output logic               exe_mem_load,
  output logic               mem_wb_load,
  output logic               if_id_flush,
  output logic               id_exe_flush,
  output logic               mem_wb_flush,
  output logic               mem_error,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // wait_cnt never exceeds MEM_TIMEOUT-1, which fits in 16 bits.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        flush_pending;
  logic        timeout_hit;
  logic        mem_stall;
  logic        branch_fire;
  logic        exe_hit;
  logic        mem_hit;
  logic        hazard;

  // True when the ID instruction reads register r.
  function automatic logic reads_reg(input logic [3:0] src1,
                                     input logic [3:0] src2,
                                     input logic       two_src,
                                     input logic [3:0] r);
    return (src1 == r) || (two_src && (src2 == r));
  endfunction

  // Hazard detection and stall / branch qualifiers.
  always_comb begin
    exe_hit     = exe_wb_en && reads_reg(id_src1, id_src2, id_two_src, exe_dest);
    mem_hit     = mem_wb_en && reads_reg(id_src1, id_src2, id_two_src, mem_dest);
    hazard      = id_valid && ((FORWARD_EN != 0) ? (exe_hit && exe_mem_read)
                                                 : (exe_hit || mem_hit));
    timeout_hit = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
    mem_stall   = mem_req && !mem_ready && !timeout_hit;
    branch_fire = (branch_taken || flush_pending) && !mem_stall;
  end

  // Memory-wait FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Memory-wait FSM next state; a dropped request also abandons the wait.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      ST_IDLE: if (mem_req && !mem_ready) state_next = ST_WAIT;
      ST_WAIT: if (!mem_req || mem_ready || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait-cycle counter: held at zero in IDLE so it starts at 0 on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Prioritised load/flush generation; everything is forced low in reset.
  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    id_exe_load  = 1'b0;
    exe_mem_load = 1'b0;
    mem_wb_load  = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        // Freeze everything; bubble into WB so the stalled MEM op retires once.
        mem_wb_flush = 1'b1;
      end else if (branch_fire) begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_exe_load  = 1'b1;
        exe_mem_load = 1'b1;
        mem_wb_load  = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (hazard) begin
        id_exe_load  = 1'b1;
        exe_mem_load = 1'b1;
        mem_wb_load  = 1'b1;
        id_exe_flush = 1'b1;
      end else begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_exe_load  = 1'b1;
        exe_mem_load = 1'b1;
        mem_wb_load  = 1'b1;
      end
    end
  end

  // Deferred branch flush, sticky error flag and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pending <= 1'b0;
      mem_error     <= 1'b0;
      stall_count   <= '0;
      flush_count   <= '0;
    end else begin
      // A branch resolved during a memory stall must not be lost.
      if (mem_stall && branch_taken) begin
        flush_pending <= 1'b1;
      end else if (branch_fire) begin
        flush_pending <= 1'b0;
      end
      if (timeout_hit) begin
        mem_error <= 1'b1;
      end
      if (!pc_load && (stall_count != '1)) begin
        stall_count <= stall_count + COUNT_W'(1);
      end
      if (branch_fire && (flush_count != '1)) begin
        flush_count <= flush_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: two configurations of pipeline_ctrl driven by the same
// stimulus; a behavioural model queues the expected outputs per cycle and a
// monitor compares them on the falling edge.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, id_valid, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;

  logic        a_pc, a_ifid, a_idexe, a_exemem, a_memwb;
  logic        a_ifid_f, a_idexe_f, a_memwb_f, a_err;
  logic [15:0] a_stalls, a_flushes;
  logic        b_pc, b_ifid, b_idexe, b_exemem, b_memwb;
  logic        b_ifid_f, b_idexe_f, b_memwb_f, b_err;
  logic [1:0]  b_stalls, b_flushes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(255), .COUNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(a_pc), .if_id_load(a_ifid), .id_exe_load(a_idexe),
    .exe_mem_load(a_exemem), .mem_wb_load(a_memwb),
    .if_id_flush(a_ifid_f), .id_exe_flush(a_idexe_f), .mem_wb_flush(a_memwb_f),
    .mem_error(a_err), .stall_count(a_stalls), .flush_count(a_flushes)
  );

  pipeline_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(4), .COUNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(b_pc), .if_id_load(b_ifid), .id_exe_load(b_idexe),
    .exe_mem_load(b_exemem), .mem_wb_load(b_memwb),
    .if_id_flush(b_ifid_f), .id_exe_flush(b_idexe_f), .mem_wb_flush(b_memwb_f),
    .mem_error(b_err), .stall_count(b_stalls), .flush_count(b_flushes)
  );

  // Expected response for one cycle: loads {pc,if_id,id_exe,exe_mem,mem_wb},
  // flushes {if_id,id_exe,mem_wb}.
  typedef struct {
    logic [4:0] loads;
    logic [2:0] flushes;
    logic       err;
    int         stall_c;
    int         flush_c;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model configuration and state, index 0 = dut_a, 1 = dut_b.
  int fwd_cfg[2] = '{1, 0};
  int tmo_cfg[2] = '{255, 4};
  int cnt_max[2] = '{65535, 3};
  bit m_waiting[2];
  int m_waited[2];
  bit m_pend[2];
  bit m_err[2];
  int m_stalls[2];
  int m_flushes[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit id_reads(input logic [3:0] r);
    return (id_src1 == r) || (id_two_src && (id_src2 == r));
  endfunction

  // Behavioural model: expected outputs for the current inputs, then advance.
  task automatic model_cycle(input int c, output exp_t e);
    bit tmo, stall, haz, brn;
    e.loads   = 5'b00000;
    e.flushes = 3'b000;
    if (!rst) begin
      m_waiting[c] = 0; m_waited[c] = 0; m_pend[c] = 0; m_err[c] = 0;
      m_stalls[c] = 0; m_flushes[c] = 0;
      e.err = 0; e.stall_c = 0; e.flush_c = 0;
      return;
    end
    e.err     = m_err[c];
    e.stall_c = m_stalls[c];
    e.flush_c = m_flushes[c];
    tmo   = m_waiting[c] && (m_waited[c] == tmo_cfg[c] - 1);
    stall = mem_req && !mem_ready && !tmo;
    if (fwd_cfg[c] != 0)
      haz = id_valid && exe_mem_read && exe_wb_en && id_reads(exe_dest);
    else
      haz = id_valid && ((exe_wb_en && id_reads(exe_dest)) || (mem_wb_en && id_reads(mem_dest)));
    brn = branch_taken || m_pend[c];
    if (stall) begin
      e.flushes = 3'b001;
      if (m_stalls[c] < cnt_max[c]) m_stalls[c]++;
      if (branch_taken) m_pend[c] = 1;
    end else if (brn) begin
      e.loads   = 5'b11111;
      e.flushes = 3'b110;
      if (m_flushes[c] < cnt_max[c]) m_flushes[c]++;
      m_pend[c] = 0;
    end else if (haz) begin
      e.loads   = 5'b00111;
      e.flushes = 3'b010;
      if (m_stalls[c] < cnt_max[c]) m_stalls[c]++;
    end else begin
      e.loads = 5'b11111;
    end
    if (tmo) m_err[c] = 1;
    if (!m_waiting[c]) begin
      if (mem_req && !mem_ready) begin
        m_waiting[c] = 1;
        m_waited[c]  = 0;
      end
    end else if (mem_ready || tmo || !mem_req) begin
      m_waiting[c] = 0;
    end else begin
      m_waited[c]++;
    end
  endtask

  // Queue the expectation for the inputs now applied, then advance one cycle.
  task automatic step();
    exp_t e;
    model_cycle(0, e);
    q_a.push_back(e);
    model_cycle(1, e);
    q_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_src1 = 0; id_src2 = 0; id_two_src = 0; id_valid = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0;
    mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Monitor: compare each presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      check("a.loads", int'({a_pc, a_ifid, a_idexe, a_exemem, a_memwb}), int'(e.loads));
      check("a.flushes", int'({a_ifid_f, a_idexe_f, a_memwb_f}), int'(e.flushes));
      check("a.mem_error", int'(a_err), int'(e.err));
      check("a.stall_count", int'(a_stalls), e.stall_c);
      check("a.flush_count", int'(a_flushes), e.flush_c);
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      check("b.loads", int'({b_pc, b_ifid, b_idexe, b_exemem, b_memwb}), int'(e.loads));
      check("b.flushes", int'({b_ifid_f, b_idexe_f, b_memwb_f}), int'(e.flushes));
      check("b.mem_error", int'(b_err), int'(e.err));
      check("b.stall_count", int'(b_stalls), e.stall_c);
      check("b.flush_count", int'(b_flushes), e.flush_c);
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    clear_in();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;

    // Load-use stall, then the same pattern with an empty ID slot.
    exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
    step();
    id_valid = 0;
    step();
    clear_in();
    step();

    // RAW against MEM through src2 (hazard only without forwarding).
    mem_wb_en = 1; mem_dest = 7; id_two_src = 1; id_src2 = 7;
    id_src1 = 1; exe_dest = 2; id_valid = 1;
    step();
    id_two_src = 0;
    step();

    // Branch and load-use in the same cycle.
    clear_in();
    exe_mem_read = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
    branch_taken = 1;
    step();
    clear_in();
    step();

    // Three-cycle SRAM wait with a branch during the stall.
    mem_req = 1;
    step();
    branch_taken = 1;
    step();
    branch_taken = 0;
    step();
    mem_ready = 1;
    step();
    clear_in();
    step();

    // Long wait: repeated timeouts on dut_b, one timeout on dut_a, then
    // reset while dut_a is mid-WAIT with its error flag set.
    mem_req = 1;
    repeat (263) step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    clear_in();
    step();

    // Randomized traffic with small register numbers to provoke matches.
    repeat (1500) begin
      rst          = ($urandom_range(0, 249) != 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      exe_dest     = 4'($urandom_range(0, 3));
      mem_dest     = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      id_valid     = ($urandom_range(0, 3) != 0);
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_read = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_req      = ($urandom_range(0, 2) == 0) ? ~mem_req : mem_req;
      mem_ready    = ($urandom_range(0, 3) == 0);
      step();
    end

    rst = 1'b1;
    clear_in();
    step();
    check("queue_drained", q_a.size() + q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
